// File: rtl/lfsr_checker_if.sv
// Symbol-stream and status bundle between an LFSR source and its checker.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [3:0]       in_data;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (output in_valid, in_data, clr_cnt,
                  input  locked, err_pulse, err_count);
  modport slave  (input  in_valid, in_data, clr_cnt,
                  output locked, err_pulse, err_count);
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit maximal-length LFSR stream:
// hunts for a consistent run, then flywheels through errors and counts them.
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  localparam logic [3:0] LOCK_V   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  logic [3:0] pred;
  logic       hit;
  logic       zero;

  assign pred = {ref_q[2:0], ref_q[3] ^ ref_q[0]};
  assign hit  = (bus.in_data == pred);
  assign zero = (bus.in_data == 4'd0);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: if (!zero) begin
          ref_d   = bus.in_data;
          match_d = 4'd0;
          state_d = VERIFY;
        end
        VERIFY: begin
          if (hit) begin
            ref_d   = bus.in_data;
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_V) begin
              state_d = LOCKED;
              run_d   = 4'd0;
            end
          end else if (!zero) begin
            ref_d   = bus.in_data;
            match_d = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (hit) begin
            ref_d = bus.in_data;
            run_d = 4'd0;
          end else begin
            // Flywheel: keep predicting from our own reference, drop the bad symbol.
            pulse_d = 1'b1;
            ref_d   = pred;
            run_d   = run_q + 4'd1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (run_q + 4'd1 == UNLOCK_V) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (bus.clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      ref_q   <= 4'd0;
      match_q <= 4'd0;
      run_q   <= 4'd0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      match_q <= match_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench: a 16-bit and a 2-bit counter checker see the same stream.
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) bus_a ();
  lfsr_checker_if #(.CNT_W(2))  bus_b ();

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs to both checkers, then sample 1ns after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.clr_cnt = c;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic lk, input logic pl,
                    input logic [15:0] ca, input logic [1:0] cb);
    chk({tag, ".locked"}, 32'(bus_a.locked), 32'(lk));
    chk({tag, ".pulse"},  32'(bus_a.err_pulse), 32'(pl));
    chk({tag, ".cnt16"},  32'(bus_a.err_count), 32'(ca));
    chk({tag, ".cnt2"},   32'(bus_b.err_count), 32'(cb));
    chk({tag, ".lockB"},  32'(bus_b.locked), 32'(lk));
  endtask

  initial begin
    // Reset held with active inputs
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h3, 1'b1);
    step(1'b1, 4'h7, 1'b0);
    st("rst_hold", 1'b0, 1'b0, 16'd0, 2'd0);
    rst = 1'b1;

    // Lock on 1,3,7,F,E
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    st("pre_lock", 1'b0, 1'b0, 16'd0, 2'd0);
    step(1'b1, 4'hE, 1'b0);
    st("lock", 1'b1, 1'b0, 16'd0, 2'd0);

    // Single error, flywheel keeps alignment (expected D)
    step(1'b1, 4'h0, 1'b0);
    st("err1", 1'b1, 1'b1, 16'd1, 2'd1);
    step(1'b1, 4'hA, 1'b0);
    st("fly_a", 1'b1, 1'b0, 16'd1, 2'd1);
    step(1'b1, 4'h5, 1'b0);
    st("fly_5", 1'b1, 1'b0, 16'd1, 2'd1);

    // Two errors, a match resets the run, then three errors unlock
    step(1'b1, 4'h0, 1'b0);
    st("e2", 1'b1, 1'b1, 16'd2, 2'd2);
    step(1'b1, 4'h0, 1'b0);
    st("e3", 1'b1, 1'b1, 16'd3, 2'd3);
    step(1'b1, 4'hC, 1'b0);
    st("run_clr", 1'b1, 1'b0, 16'd3, 2'd3);
    step(1'b1, 4'h0, 1'b0);
    st("e4", 1'b1, 1'b1, 16'd4, 2'd3);
    step(1'b1, 4'h0, 1'b0);
    st("e5", 1'b1, 1'b1, 16'd5, 2'd3);
    step(1'b1, 4'h0, 1'b0);
    st("unlock", 1'b0, 1'b1, 16'd6, 2'd3);

    // Re-lock from a different phase; count holds
    step(1'b1, 4'h2, 1'b0);
    st("hunt_cap", 1'b0, 1'b0, 16'd6, 2'd3);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    st("relock_pre", 1'b0, 1'b0, 16'd6, 2'd3);
    step(1'b1, 4'h3, 1'b0);
    st("relock", 1'b1, 1'b0, 16'd6, 2'd3);

    // Asynchronous reset mid-lock
    #2 rst = 1'b0;
    #1;
    st("async_rst", 1'b0, 1'b0, 16'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0);
    rst = 1'b1;

    // Lock with gaps carrying garbage
    step(1'b1, 4'h1, 1'b0); step(1'b0, 4'h5, 1'b0);
    step(1'b1, 4'h3, 1'b0); step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h7, 1'b0); step(1'b0, 4'h9, 1'b0);
    step(1'b1, 4'hF, 1'b0); step(1'b0, 4'h0, 1'b0);
    st("gap_pre", 1'b0, 1'b0, 16'd0, 2'd0);
    step(1'b1, 4'hE, 1'b0);
    st("gap_lock", 1'b1, 1'b0, 16'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0);
    st("gap_idle", 1'b1, 1'b0, 16'd0, 2'd0);

    // Clear wins over a same-cycle error; pulse still fires
    step(1'b1, 4'h0, 1'b1);
    st("clr_err", 1'b1, 1'b1, 16'd0, 2'd0);
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    st("post_clr", 1'b1, 1'b1, 16'd1, 2'd1);
    step(1'b1, 4'hB, 1'b0);
    st("match_b", 1'b1, 1'b0, 16'd1, 2'd1);
    step(1'b0, 4'h0, 1'b1);
    st("clr_idle", 1'b1, 1'b0, 16'd0, 2'd0);

    // VERIFY mismatch restarts the run from the bad symbol, uncounted
    rst = 1'b0;
    #1 rst = 1'b1;
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h9, 1'b0);
    st("ver_mis", 1'b0, 1'b0, 16'd0, 2'd0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    st("ver_pre", 1'b0, 1'b0, 16'd0, 2'd0);
    step(1'b1, 4'h1, 1'b0);
    st("ver_lock", 1'b1, 1'b0, 16'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
